// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: front-end fetch stage feeding the IF/ID register.
// Issues in-order word requests to instruction memory. Buffers returned {pc, instr}
// pairs in a DEPTH-entry prefetch FIFO and presents the head to decode. A redirect
// flushes the FIFO; responses to requests already in flight are discarded.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   fetch_en                          allow new requests to issue
//   mem_req_valid/ready/addr          request channel to instruction memory
//   mem_rsp_valid/data                in-order responses, no backpressure
//   redirect_valid/pc                 flush and restart fetch at redirect_pc
//   if_valid/ready/pc/instr           head of prefetch FIFO toward decode
//   err_unexp_rsp                     sticky: response with nothing outstanding
module instr_fetch_unit #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  err_unexp_rsp
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]       live_q, live_d;
  logic [CntW-1:0]       drop_q, drop_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];

  logic                  credit_ok;
  logic                  req_fire;
  logic                  push;
  logic                  pop;
  logic [CntW-1:0]       stale_total;
  logic [DATA_WIDTH-1:0] redirect_aligned;
  logic                  unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_aligned    = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

  // Credits cover both FIFO occupancy and in-flight live requests, so every live
  // response is guaranteed a FIFO slot.
  assign credit_ok     = ({1'b0, live_q} + {1'b0, count_q}) < (CntW + 1)'(DEPTH);
  assign mem_req_valid = (state_q == StRun) && !redirect_valid && credit_ok;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign mem_req_addr  = fetch_pc_q;

  assign if_valid      = (count_q != '0) && !redirect_valid;
  assign pop           = if_valid && if_ready;
  assign if_pc         = pc_mem_q[rd_ptr_q];
  assign if_instr      = instr_mem_q[rd_ptr_q];
  assign err_unexp_rsp = err_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    live_d      = live_q;
    drop_d      = drop_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q;
    push        = 1'b0;
    stale_total = drop_q + live_q;

    if (redirect_valid) begin
      // Everything in flight becomes stale; a response arriving now is one of them.
      if (mem_rsp_valid) begin
        if (stale_total == '0) begin
          err_d = 1'b1;
        end else begin
          stale_total = stale_total - CntW'(1);
        end
      end
      drop_d     = stale_total;
      live_d     = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
      end
      if (mem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CntW'(1);
        end else if (live_q != '0) begin
          push = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      live_d = live_q + CntW'(req_fire) - CntW'(push);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        rsp_pc_d = rsp_pc_q + DATA_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= {RESET_PC[DATA_WIDTH-1:2], 2'b00};
      rsp_pc_q   <= {RESET_PC[DATA_WIDTH-1:2], 2'b00};
      live_q     <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle:  if (fetch_en)  state_q <= StRun;
        StRun:   if (!fetch_en) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        instr_mem_q[wr_ptr_q] <= mem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        err_unexp_rsp;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .err_unexp_rsp  (err_unexp_rsp)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int lat          = 1;
  int n_req        = 0;
  int n_pop        = 0;
  logic force_rsp  = 1'b0;

  // Memory model: accepted requests waiting for their response cycle.
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  // Scoreboard: {pc, instr} expected at decode, in order.
  logic [31:0] exp_pc    [$];
  logic [31:0] exp_instr [$];

  // Values sampled mid-cycle by step().
  int          s_cyc;
  logic        s_req_valid, s_if_valid, s_err, s_rsp_valid;
  logic [31:0] s_req_addr, s_if_pc, s_pop_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // One clock cycle: present a memory response, sample outputs, track the scoreboard.
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step();
    logic [31:0] ep, ei;
    if (force_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hBAD0_0BAD;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    #1;
    s_cyc       = cyc;
    s_rsp_valid = mem_rsp_valid;
    s_req_valid = mem_req_valid;
    s_req_addr  = mem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_err       = err_unexp_rsp;
    if (mem_req_valid && mem_req_ready) begin
      pend_addr.push_back(mem_req_addr);
      pend_due.push_back(cyc + lat);
      exp_pc.push_back(mem_req_addr);
      exp_instr.push_back(instr_of(mem_req_addr));
      n_req++;
    end
    if (if_valid && if_ready) begin
      n_pop++;
      s_pop_pc = if_pc;
      tests_run++;
      if (exp_pc.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_extra: popped pc=%h instr=%h with nothing expected",
                 if_pc, if_instr);
      end else begin
        ep = exp_pc.pop_front();
        ei = exp_instr.pop_front();
        if (if_pc !== ep || if_instr !== ei) begin
          tests_failed++;
          $display("FAIL scoreboard: got pc=%h instr=%h, expected pc=%h instr=%h",
                   if_pc, if_instr, ep, ei);
        end
      end
    end
    if (redirect_valid) begin
      exp_pc.delete();
      exp_instr.delete();
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    fetch_en = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    step();
    while ((pend_addr.size() != 0 || exp_pc.size() != 0 || s_req_valid) && guard < 60) begin
      step();
      guard++;
    end
    tests_run++;
    if (guard >= 60) begin
      tests_failed++;
      $display("FAIL drain_timeout: pending=%0d expected=%0d, required 0", pend_addr.size(),
               exp_pc.size());
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (mem_req_valid !== 1'b0 || if_valid !== 1'b0 || mem_req_addr !== 32'h0 ||
        if_pc !== 32'h0 || if_instr !== 32'h0 || err_unexp_rsp !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: req_v=%b if_v=%b addr=%h pc=%h instr=%h err=%b, required 0",
               mem_req_valid, if_valid, mem_req_addr, if_pc, if_instr, err_unexp_rsp);
    end
  endtask

  task automatic test_stream();
    int first_valid = -1;
    int pop0;
    reset_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1; mem_req_ready = 1'b1; lat = 1;
    cyc = 0;
    pop0 = n_pop;
    for (int i = 0; i < 14; i++) begin
      step();
      if (s_if_valid && first_valid < 0) first_valid = s_cyc;
      if (s_cyc == 1) begin
        tests_run++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
          tests_failed++;
          $display("FAIL stream_first_req: valid=%b addr=%h, required 1 / 0", s_req_valid,
                   s_req_addr);
        end
      end
    end
    tests_run++;
    if (first_valid != 3) begin
      tests_failed++;
      $display("FAIL stream_first_valid: cycle %0d, required 3", first_valid);
    end
    tests_run++;
    if (n_pop - pop0 != 11) begin
      tests_failed++;
      $display("FAIL stream_rate: %0d pops, required 11", n_pop - pop0);
    end
  endtask

  task automatic test_backpressure();
    int req0, pop0, guard;
    drain();
    if_ready = 1'b0; fetch_en = 1'b1;
    req0 = n_req;
    repeat (10) step();
    tests_run++;
    if (n_req - req0 != 4 || s_req_valid !== 1'b0 || s_if_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_fill: reqs=%0d req_v=%b if_v=%b, required 4 / 0 / 1", n_req - req0,
               s_req_valid, s_if_valid);
    end
    if_ready = 1'b1; fetch_en = 1'b0;
    pop0 = n_pop;
    guard = 0;
    while (exp_pc.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    step();
    tests_run++;
    if (n_pop - pop0 != 4) begin
      tests_failed++;
      $display("FAIL bp_resume: %0d pops, required 4", n_pop - pop0);
    end
  endtask

  task automatic test_redirect_stale();
    int pop0, guard;
    drain();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0; fetch_en = 1'b1; lat = 4;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h10 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL rd_setup_req%0d: valid=%b addr=%h, required 1 / %h", i, s_req_valid,
                 s_req_addr, 32'h10 + 32'(4 * i));
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    tests_run++;
    if (s_req_valid !== 1'b0 || s_if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_cycle_idle: req_v=%b if_v=%b, required 0 / 0", s_req_valid, s_if_valid);
    end
    redirect_valid = 1'b0;
    step();
    tests_run++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL rd_new_addr: valid=%b addr=%h, required 1 / 00000100", s_req_valid,
               s_req_addr);
    end
    pop0 = n_pop;
    guard = 0;
    while (n_pop == pop0 && guard < 30) begin
      step();
      guard++;
    end
    tests_run++;
    if (n_pop == pop0 || s_pop_pc !== 32'h100) begin
      tests_failed++;
      $display("FAIL rd_first_pc: pops=%0d pc=%h, required pc 00000100", n_pop - pop0, s_pop_pc);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int pop0, guard;
    drain();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0; fetch_en = 1'b1; lat = 2;
    repeat (4) step();
    // FIFO holds 0x40, 0x44/0x48 in flight; 0x44 returns during the redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h300; if_ready = 1'b1;
    step();
    tests_run++;
    if (s_rsp_valid !== 1'b1 || s_req_valid !== 1'b0 || s_if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsc_cycle: rsp_v=%b req_v=%b if_v=%b, required 1 / 0 / 0", s_rsp_valid,
               s_req_valid, s_if_valid);
    end
    redirect_valid = 1'b0;
    pop0 = n_pop;
    guard = 0;
    while (n_pop == pop0 && guard < 30) begin
      step();
      guard++;
    end
    tests_run++;
    if (n_pop == pop0 || s_pop_pc !== 32'h300) begin
      tests_failed++;
      $display("FAIL rsc_first_pc: pops=%0d pc=%h, required pc 00000300", n_pop - pop0, s_pop_pc);
    end
    repeat (6) step();
    tests_run++;
    if (s_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsc_no_err: err=%b, required 0", s_err);
    end
  endtask

  task automatic test_req_stall();
    drain();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0; mem_req_ready = 1'b0; fetch_en = 1'b1; lat = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFF8) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: valid=%b addr=%h, required 1 / fffffff8", i, s_req_valid,
                 s_req_addr);
      end
    end
    mem_req_ready = 1'b1;
    step();
    step();
    tests_run++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL stall_advance: valid=%b addr=%h, required 1 / fffffffc", s_req_valid,
               s_req_addr);
    end
    step();
    tests_run++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL pc_wrap: valid=%b addr=%h, required 1 / 00000000", s_req_valid, s_req_addr);
    end
    drain();
  endtask

  task automatic test_unexp_rsp();
    int guard;
    logic [31:0] head;
    drain();
    if_ready = 1'b0; fetch_en = 1'b1; lat = 1;
    repeat (3) step();
    fetch_en = 1'b0;
    repeat (4) step();
    head = exp_pc[0];
    force_rsp = 1'b1;
    step();
    force_rsp = 1'b0;
    step();
    tests_run++;
    if (s_err !== 1'b1 || s_if_valid !== 1'b1 || s_if_pc !== head) begin
      tests_failed++;
      $display("FAIL unexp_set: err=%b if_v=%b pc=%h, required 1 / 1 / %h", s_err, s_if_valid,
               s_if_pc, head);
    end
    if_ready = 1'b1;
    guard = 0;
    while (exp_pc.size() != 0 && guard < 10) begin
      step();
      guard++;
    end
    repeat (3) step();
    tests_run++;
    if (s_if_valid !== 1'b0 || s_err !== 1'b1 || exp_pc.size() != 0) begin
      tests_failed++;
      $display("FAIL unexp_fifo: if_v=%b err=%b left=%0d, required 0 / 1 / 0", s_if_valid, s_err,
               exp_pc.size());
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (err_unexp_rsp !== 1'b0 || if_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL unexp_clear: err=%b if_v=%b req_v=%b, required 0", err_unexp_rsp, if_valid,
               mem_req_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; fetch_en = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    s_req_valid = 1'b0; s_if_valid = 1'b0; s_err = 1'b0; s_rsp_valid = 1'b0;
    s_req_addr = '0; s_if_pc = '0; s_pop_pc = '0; s_cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_same_cycle();
    test_req_stall();
    test_unexp_rsp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
